// File: rtl/pcs_pkg.sv
// Shared constants for the PCS transmit path: ordered-set codes,
// special-character octets and the code-group FSM state encoding.
package pcs_pkg;

    // Ordered-set codes presented by the ordered-set transmitter
    localparam int unsigned OS_T  = 1;
    localparam int unsigned OS_R  = 2;
    localparam int unsigned OS_I  = 3;
    localparam int unsigned OS_D  = 4;
    localparam int unsigned OS_S  = 5;
    localparam int unsigned OS_V  = 6;
    localparam int unsigned OS_LI = 7;

    // Special-character octets (encoded with is_k set)
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // Second octet of /I1/ and /I2/
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    typedef enum logic [1:0] {
        SET_START = 2'd0,
        IDLE_I1   = 2'd1,
        IDLE_I2   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/encoder_8b10b.sv
// Combinational 8B/10B encoder. Code bit 9 is 'a' (sent first), bit 0 is 'j'.
// The RD- form of each sub-block is tabulated; the RD+ form is derived by
// complementing where the code is disparity-dependent.
module encoder_8b10b (
    input  logic [7:0] data,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic [5:0] six_neg;
    logic [5:0] six;
    logic       six_unbal;
    logic       rd_mid;
    logic [3:0] four_neg;
    logic [3:0] four;
    logic       four_unbal;
    logic       use_a7;

    assign x   = data[4:0];
    assign y   = data[7:5];
    assign k28 = is_k && (x == 5'd28);

    // 5b/6b sub-block; D.07 is balanced but still has two forms
    always_comb begin
        six_neg = 6'b000000;
        case (x)
            5'd0:  six_neg = 6'b100111;
            5'd1:  six_neg = 6'b011101;
            5'd2:  six_neg = 6'b101101;
            5'd3:  six_neg = 6'b110001;
            5'd4:  six_neg = 6'b110101;
            5'd5:  six_neg = 6'b101001;
            5'd6:  six_neg = 6'b011001;
            5'd7:  six_neg = 6'b111000;
            5'd8:  six_neg = 6'b111001;
            5'd9:  six_neg = 6'b100101;
            5'd10: six_neg = 6'b010101;
            5'd11: six_neg = 6'b110100;
            5'd12: six_neg = 6'b001101;
            5'd13: six_neg = 6'b101100;
            5'd14: six_neg = 6'b011100;
            5'd15: six_neg = 6'b010111;
            5'd16: six_neg = 6'b011011;
            5'd17: six_neg = 6'b100011;
            5'd18: six_neg = 6'b010011;
            5'd19: six_neg = 6'b110010;
            5'd20: six_neg = 6'b001011;
            5'd21: six_neg = 6'b101010;
            5'd22: six_neg = 6'b011010;
            5'd23: six_neg = 6'b111010;
            5'd24: six_neg = 6'b110011;
            5'd25: six_neg = 6'b100110;
            5'd26: six_neg = 6'b010110;
            5'd27: six_neg = 6'b110110;
            5'd28: six_neg = 6'b001110;
            5'd29: six_neg = 6'b101110;
            5'd30: six_neg = 6'b011110;
            default: six_neg = 6'b101011;
        endcase
        if (k28) begin
            six_neg = 6'b001111;
        end
        six_unbal = ($countones(six_neg) != 3);
        six       = (rd_in && (six_unbal || x == 5'd7)) ? ~six_neg : six_neg;
        rd_mid    = rd_in ^ six_unbal;
    end

    // 3b/4b sub-block, including the alternate D.x.A7 form that avoids runs of five
    always_comb begin
        four_neg   = 4'b0000;
        use_a7     = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                     ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        four_unbal = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
        if (is_k) begin
            case (y)
                3'd0: four_neg = 4'b1011;
                3'd1: four_neg = 4'b0110;
                3'd2: four_neg = 4'b1010;
                3'd3: four_neg = 4'b1100;
                3'd4: four_neg = 4'b1101;
                3'd5: four_neg = 4'b0101;
                3'd6: four_neg = 4'b1001;
                default: four_neg = 4'b0111;
            endcase
            four = rd_mid ? ~four_neg : four_neg;
        end else begin
            case (y)
                3'd0: four_neg = 4'b1011;
                3'd1: four_neg = 4'b1001;
                3'd2: four_neg = 4'b0101;
                3'd3: four_neg = 4'b1100;
                3'd4: four_neg = 4'b1101;
                3'd5: four_neg = 4'b1010;
                3'd6: four_neg = 4'b0110;
                default: four_neg = use_a7 ? 4'b0111 : 4'b1110;
            endcase
            four = (rd_mid && (four_unbal || y == 3'd3)) ? ~four_neg : four_neg;
        end
        rd_out = rd_mid ^ four_unbal;
        code   = {six, four};
    end

endmodule

// File: rtl/transmit_code_group.sv
// PCS transmit code-group machine: turns ordered-set codes into 10-bit code
// groups, tracks running disparity and even/odd position, and reports the
// last code group of each ordered set back to the ordered-set transmitter.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// SET_START | sample tx_o_set/TXD, send a one-group set or the K28.5 of /I/
// IDLE_I1   | second group of /I1/ (D5.6), K28.5 was sent from RD+
// IDLE_I2   | second group of /I2/ (D16.2), K28.5 was sent from RD-
module transmit_code_group
    import pcs_pkg::*;
#(
    parameter int OSET_W = 7
) (
    input  logic              GTX_CLK,
    input  logic              mr_main_reset,
    input  logic [OSET_W-1:0] tx_o_set,
    input  logic [7:0]        TXD,
    output logic [9:0]        tx_code_group,
    output logic              tx_even,
    output logic              TX_OSET_indicate,
    output logic              running_disparity
);

    tx_state_e  state_q, state_d;
    logic [9:0] code_q;
    logic       even_q, even_d;
    logic       ind_q, ind_d;
    logic       rd_q;
    logic [7:0] enc_data;
    logic       enc_k;
    logic [9:0] enc_code;
    logic       enc_rd;

    encoder_8b10b u_enc (
        .data   (enc_data),
        .is_k   (enc_k),
        .rd_in  (rd_q),
        .code   (enc_code),
        .rd_out (enc_rd)
    );

    // Next state and the octet to encode; unknown codes fall back to /V/
    always_comb begin
        state_d  = state_q;
        even_d   = even_q;
        ind_d    = 1'b0;
        enc_data = K30_7;
        enc_k    = 1'b1;
        case (state_q)
            SET_START: begin
                even_d = ~even_q;
                ind_d  = 1'b1;
                if (tx_o_set == OSET_W'(OS_S)) begin
                    enc_data = K27_7;
                end else if (tx_o_set == OSET_W'(OS_T)) begin
                    enc_data = K29_7;
                end else if (tx_o_set == OSET_W'(OS_R)) begin
                    enc_data = K23_7;
                end else if (tx_o_set == OSET_W'(OS_D)) begin
                    enc_data = TXD;
                    enc_k    = 1'b0;
                end else if (tx_o_set == OSET_W'(OS_I) || tx_o_set == OSET_W'(OS_LI)) begin
                    enc_data = K28_5;
                    even_d   = 1'b1;
                    ind_d    = 1'b0;
                    state_d  = rd_q ? IDLE_I1 : IDLE_I2;
                end
            end
            IDLE_I1: begin
                enc_data = D5_6;
                enc_k    = 1'b0;
                even_d   = 1'b0;
                ind_d    = 1'b1;
                state_d  = SET_START;
            end
            IDLE_I2: begin
                enc_data = D16_2;
                enc_k    = 1'b0;
                even_d   = 1'b0;
                ind_d    = 1'b1;
                state_d  = SET_START;
            end
            default: begin
                state_d = SET_START;
            end
        endcase
    end

    // Register the code group, disparity and handshake outputs every clock
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q <= SET_START;
            code_q  <= 10'h000;
            even_q  <= 1'b0;
            ind_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= enc_code;
            even_q  <= even_d;
            ind_q   <= ind_d;
            rd_q    <= enc_rd;
        end
    end

    assign tx_code_group     = code_q;
    assign tx_even           = even_q;
    assign TX_OSET_indicate  = ind_q;
    assign running_disparity = rd_q;

endmodule

// File: tb/tb_transmit_code_group.sv
// Scoreboard bench for transmit_code_group: stimulus pushes the expected code
// group for each clock it drives; the monitor pops and compares after each edge.
module tb_transmit_code_group;

    localparam int OSET_W = 7;

    localparam logic [6:0] S_T = 7'd1, S_R = 7'd2, S_I = 7'd3, S_D = 7'd4;
    localparam logic [6:0] S_S = 7'd5, S_V = 7'd6, S_LI = 7'd7;

    localparam logic [9:0] C_K28N = 10'b0011111010;
    localparam logic [9:0] C_K28P = 10'b1100000101;
    localparam logic [9:0] C_D162 = 10'b1001000101;
    localparam logic [9:0] C_D56  = 10'b1010010110;
    localparam logic [9:0] C_K277 = 10'b1101101000;
    localparam logic [9:0] C_K297 = 10'b1011101000;
    localparam logic [9:0] C_K237 = 10'b1110101000;
    localparam logic [9:0] C_K307 = 10'b0111101000;

    logic              GTX_CLK;
    logic              mr_main_reset;
    logic [OSET_W-1:0] tx_o_set;
    logic [7:0]        TXD;
    logic [9:0]        tx_code_group;
    logic              tx_even;
    logic              TX_OSET_indicate;
    logic              running_disparity;

    typedef struct {
        logic [9:0] code;
        logic       even;
        logic       ind;
        logic       rd;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic ev_m     = 1'b0;

    transmit_code_group #(.OSET_W(OSET_W)) dut (
        .GTX_CLK           (GTX_CLK),
        .mr_main_reset     (mr_main_reset),
        .tx_o_set          (tx_o_set),
        .TXD               (TXD),
        .tx_code_group     (tx_code_group),
        .tx_even           (tx_even),
        .TX_OSET_indicate  (TX_OSET_indicate),
        .running_disparity (running_disparity)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // evk: 0 = position toggles, 1 = forced even, 2 = forced odd
    task automatic issue(input logic [6:0] os, input logic [7:0] d, input logic [9:0] code,
                         input logic ind, input logic rd, input int evk, input string nm);
        exp_t e;
        @(negedge GTX_CLK);
        tx_o_set = os;
        TXD      = d;
        if (evk == 0)      ev_m = ~ev_m;
        else if (evk == 1) ev_m = 1'b1;
        else               ev_m = 1'b0;
        e.code = code;
        e.even = ev_m;
        e.ind  = ind;
        e.rd   = rd;
        e.nm   = nm;
        q.push_back(e);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_code"}, tx_code_group, 10'h000);
        chk({nm, "_even"}, {9'd0, tx_even}, 10'd0);
        chk({nm, "_ind"},  {9'd0, TX_OSET_indicate}, 10'd0);
        chk({nm, "_rd"},   {9'd0, running_disparity}, 10'd0);
    endtask

    // Monitor: every edge presents a code group; compare it if one is expected
    initial begin
        exp_t e;
        forever begin
            @(posedge GTX_CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, "_code"}, tx_code_group, e.code);
                chk({e.nm, "_even"}, {9'd0, tx_even}, {9'd0, e.even});
                chk({e.nm, "_ind"},  {9'd0, TX_OSET_indicate}, {9'd0, e.ind});
                chk({e.nm, "_rd"},   {9'd0, running_disparity}, {9'd0, e.rd});
            end
        end
    end

    initial begin
        mr_main_reset = 1'b0;
        tx_o_set      = S_I;
        TXD           = 8'h00;
        #22;
        chk_reset("por");

        // 1: held /I/ from reset, releasing on the first stimulus negedge
        issue(S_I, 8'h00, C_K28N, 1'b0, 1'b1, 1, "t1_k0");
        mr_main_reset = 1'b1;
        issue(S_I, 8'h00, C_D162, 1'b1, 1'b0, 2, "t1_d0");
        for (int i = 0; i < 2; i++) begin
            issue(S_I, 8'h00, C_K28N, 1'b0, 1'b1, 1, "t1_k");
            issue(S_I, 8'h00, C_D162, 1'b1, 1'b0, 2, "t1_d");
        end

        // 2: data octets from RD-
        issue(S_D, 8'h00, 10'b1001110100, 1'b1, 1'b0, 0, "t2_d00");
        issue(S_D, 8'h03, 10'b1100011011, 1'b1, 1'b1, 0, "t2_d03");

        // 3: /I/ from RD+ gives /I1/
        issue(S_I, 8'h00, C_K28P, 1'b0, 1'b0, 1, "t3_k");
        issue(S_I, 8'h00, C_D56,  1'b1, 1'b0, 2, "t3_d56");

        // 4: /S/ D0.0 /T/ /R/ /R/
        issue(S_S, 8'h00, C_K277, 1'b1, 1'b0, 0, "t4_s");
        issue(S_D, 8'h00, 10'b1001110100, 1'b1, 1'b0, 0, "t4_d");
        issue(S_T, 8'h00, C_K297, 1'b1, 1'b0, 0, "t4_t");
        issue(S_R, 8'h00, C_K237, 1'b1, 1'b0, 0, "t4_r1");
        issue(S_R, 8'h00, C_K237, 1'b1, 1'b0, 0, "t4_r2");

        // 5: /S/ presented during the K28.5 is ignored until SET_START
        issue(S_I, 8'h00, C_K28N, 1'b0, 1'b1, 1, "t5_k");
        issue(S_S, 8'h00, C_D162, 1'b1, 1'b0, 2, "t5_d162");
        issue(S_S, 8'h00, C_K277, 1'b1, 1'b0, 0, "t5_s");

        // /V/, out-of-range codes, /LI/ and D.x.7 forms
        issue(S_V,   8'h00, C_K307, 1'b1, 1'b0, 0, "v");
        issue(7'd0,  8'h00, C_K307, 1'b1, 1'b0, 0, "code0");
        issue(7'd8,  8'h00, C_K307, 1'b1, 1'b0, 0, "code8");
        issue(S_LI,  8'h00, C_K28N, 1'b0, 1'b1, 1, "li_k");
        issue(S_LI,  8'h00, C_D162, 1'b1, 1'b0, 2, "li_d");
        issue(S_D,   8'hF1, 10'b1000110111, 1'b1, 1'b1, 0, "d17_7_a7n");
        issue(S_D,   8'hEB, 10'b1101001000, 1'b1, 1'b0, 0, "d11_7_a7p");
        issue(S_D,   8'hE0, 10'b1001110001, 1'b1, 1'b0, 0, "d0_7_p7");

        // 6: reset during the K28.5 of /I/ abandons the set
        issue(S_I, 8'h00, C_K28N, 1'b0, 1'b1, 1, "t6_k");
        @(posedge GTX_CLK);
        #3;
        mr_main_reset = 1'b0;
        #1;
        chk_reset("t6_rst");
        ev_m = 1'b0;
        issue(S_I, 8'h00, C_K28N, 1'b0, 1'b1, 1, "t6_k_after");
        mr_main_reset = 1'b1;
        issue(S_I, 8'h00, C_D162, 1'b1, 1'b0, 2, "t6_d_after");

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge GTX_CLK);
            #2;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
